jt10_adpcm_romarb: RTL and testbench

//  Shares one external sample-ROM read port between the ADPCM-A driver and the ADPCM-B driver.

---
 rtl/jt10_adpcm_pkg.sv | 6 +
 rtl/jt10_adpcm_romarb_cache.sv | 31 +++
 rtl/jt10_adpcm_romarb.sv | 89 ++++++++
 tb/tb_jt10_adpcm_romarb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt10_adpcm_pkg.sv
// jt10_adpcm_pkg: shared FSM state and grant encodings for the ADPCM ROM arbiter
package jt10_adpcm_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;
endpackage

// File: rtl/jt10_adpcm_romarb_cache.sv
// jt10_adpcm_romarb_cache: one-byte last-fetch cache (tag/data/valid) for one requester
module jt10_adpcm_romarb_cache #(
  parameter int AW = 24
) (
  input  logic          rst_n,
  input  logic          clk,
  input  logic          flush,
  input  logic          fill,
  input  logic          kill,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] fill_addr,
  input  logic [7:0]    fill_data,
  output logic          hit,
  output logic [7:0]    dout
);
  logic          vld;
  logic [AW-1:0] tag;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld  <= 1'b0;
      tag  <= '0;
      dout <= '0;
    end else begin
      if (fill) begin
        tag  <= fill_addr;
        dout <= fill_data;
      end
      vld <= flush ? 1'b0 : fill ? !kill : vld;
    end
  assign hit = vld && tag == addr;
endmodule

// File: rtl/jt10_adpcm_romarb.sv
// jt10_adpcm_romarb: round-robin sharing of one sample-ROM read port between ADPCM-A and ADPCM-B
module jt10_adpcm_romarb
  import jt10_adpcm_pkg::*;
#(
  parameter int AW   = 24,
  parameter int TOUT = 255
) (
  input  logic          rst_n,
  input  logic          clk,
  input  logic          flush,
  input  logic          a_rd,
  input  logic [AW-1:0] a_addr,
  output logic [7:0]    a_dout,
  output logic          a_ok,
  input  logic          b_rd,
  input  logic [AW-1:0] b_addr,
  output logic [7:0]    b_dout,
  output logic          b_ok,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_data,
  input  logic          mem_ok,
  output logic          timeout
);
  localparam int CW = TOUT > 0 ? $clog2(TOUT + 1) : 1;
  state_t        state, state_nx;
  logic          gnt, gnt_nx, last, kill, go, done, abort;
  logic          hit_a, hit_b, pend_a, pend_b;
  logic [CW-1:0] cnt;
  assign pend_a = a_rd && !hit_a;
  assign pend_b = b_rd && !hit_b;
  assign a_ok   = a_rd && hit_a;
  assign b_ok   = b_rd && hit_b;
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    go       = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    if (state == IDLE) begin
      go       = pend_a || pend_b;
      gnt_nx   = pend_a && pend_b ? !last : (pend_b ? GNT_B : GNT_A);
      state_nx = go ? BUSY : IDLE;
    end else begin
      done     = mem_ok;
      abort    = !mem_ok && TOUT != 0 && cnt == CW'(TOUT - 1);
      state_nx = done || abort ? IDLE : BUSY;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt      <= GNT_A;
      last     <= GNT_B;
      kill     <= 1'b0;
      cnt      <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= abort;
      gnt     <= gnt_nx;
      // a flush seen during the fetch must survive until the fill lands
      kill    <= state == BUSY && !done && !abort && (kill || flush);
      if (go) begin
        mem_addr <= gnt_nx == GNT_B ? b_addr : a_addr;
        mem_rd   <= 1'b1;
        cnt      <= '0;
      end else if (state == BUSY) cnt <= cnt + 1'b1;
      if (done || abort) begin
        mem_rd <= 1'b0;
        last   <= gnt;
      end
    end
  jt10_adpcm_romarb_cache #(.AW(AW)) u_cache_a (
    .rst_n(rst_n), .clk(clk), .flush(flush),
    .fill(done && gnt == GNT_A), .kill(kill || flush),
    .addr(a_addr), .fill_addr(mem_addr), .fill_data(mem_data),
    .hit(hit_a), .dout(a_dout)
  );
  jt10_adpcm_romarb_cache #(.AW(AW)) u_cache_b (
    .rst_n(rst_n), .clk(clk), .flush(flush),
    .fill(done && gnt == GNT_B), .kill(kill || flush),
    .addr(b_addr), .fill_addr(mem_addr), .fill_data(mem_data),
    .hit(hit_b), .dout(b_dout)
  );
endmodule

// File: tb/tb_jt10_adpcm_romarb.sv
// tb_jt10_adpcm_romarb: scenario tasks plus randomized traffic against a behavioural ROM model
module tb_jt10_adpcm_romarb;
  logic        rst_n = 1'b0, clk = 1'b0, flush = 1'b0;
  logic        a_rd = 1'b0, b_rd = 1'b0;
  logic [23:0] a_addr = '0, b_addr = '0, mem_addr;
  logic [7:0]  a_dout, b_dout, mem_data = '0;
  logic        a_ok, b_ok, mem_rd, mem_ok = 1'b0, timeout;
  int pass_n = 0, total_n = 0;
  int lat = 3, ovr = -1, mcnt = 0;
  bit silent = 1'b0;

  jt10_adpcm_romarb #(.AW(24), .TOUT(8)) dut (
    .rst_n(rst_n), .clk(clk), .flush(flush),
    .a_rd(a_rd), .a_addr(a_addr), .a_dout(a_dout), .a_ok(a_ok),
    .b_rd(b_rd), .b_addr(b_addr), .b_dout(b_dout), .b_ok(b_ok),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_ok(mem_ok), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_fn(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // ROM model: answers lat cycles after mem_rd rises, or never when silent
  always @(negedge clk) begin
    if (!mem_rd || silent) begin
      mem_ok = 1'b0;
      mcnt   = 0;
    end else begin
      mcnt++;
      mem_ok   = (mcnt == lat);
      mem_data = ovr >= 0 ? ovr[7:0] : mem_fn(mem_addr);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; flush = 1'b0; a_rd = 1'b0; b_rd = 1'b0;
    a_addr = '0; b_addr = '0; silent = 1'b0; ovr = -1; lat = 3;
    step; step;
    rst_n = 1'b1;
  endtask

  task automatic wait_rd(output bit got);
    int n = 0;
    while (!mem_rd && n < 50) begin step; n++; end
    got = mem_rd;
  endtask

  task automatic wait_fall(output bit got);
    int n = 0;
    while (mem_rd && n < 50) begin step; n++; end
    got = !mem_rd;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    total_n++;
    if ({a_ok, b_ok, mem_rd, timeout, mem_addr, a_dout, b_dout} !== '0)
      $display("FAIL reset: outputs=%h required 0", {a_ok, b_ok, mem_rd, timeout, mem_addr, a_dout, b_dout});
    else pass_n++;
    do_reset;
  endtask

  task automatic test_basic;
    bit got;
    int n = 0, extra = 0;
    do_reset;
    ovr = 8'hA5; a_addr = 24'h012345; a_rd = 1'b1;
    wait_rd(got);
    total_n++;
    if (!got || mem_addr !== 24'h012345) $display("FAIL basic_addr: got=%0b mem_addr=%h required 012345", got, mem_addr);
    else pass_n++;
    while (!a_ok && n < 20) begin step; n++; end
    total_n++;
    if (n !== 3) $display("FAIL basic_latency: a_ok after %0d cycles, required 3", n);
    else pass_n++;
    total_n++;
    if (a_dout !== 8'hA5 || mem_rd !== 1'b0) $display("FAIL basic_data: a_dout=%h mem_rd=%b required a5/0", a_dout, mem_rd);
    else pass_n++;
    for (int i = 0; i < 5; i++) begin step; if (mem_rd || !a_ok) extra++; end
    total_n++;
    if (extra !== 0) $display("FAIL basic_rehit: %0d cycles with fetch or miss, required 0", extra);
    else pass_n++;
    a_rd = 1'b0;
  endtask

  task automatic test_round_robin;
    bit got, prev = 1'b0;
    int n = 0, gap = 0, k = 0, port;
    do_reset;
    lat = 2; a_addr = 24'h000010; b_addr = 24'h100020; a_rd = 1'b1; b_rd = 1'b1;
    while (n < 4 && k < 200) begin
      step; k++;
      if (mem_rd && !prev) begin
        port = (mem_addr === b_addr) ? 1 : 0;
        total_n++;
        if (port !== n % 2) $display("FAIL rr_order: grant %0d went to port %0d, required %0d", n, port, n % 2);
        else pass_n++;
        if (n > 0) begin
          total_n++;
          if (gap !== 1) $display("FAIL rr_gap: %0d idle cycles before grant %0d, required 1", gap, n);
          else pass_n++;
        end
        gap = 0; n++;
      end
      if (!mem_rd) gap++;
      prev = mem_rd;
      if (a_ok) a_addr++;
      if (b_ok) b_addr++;
    end
    total_n++;
    if (n !== 4) $display("FAIL rr_count: %0d grants seen, required 4", n);
    else pass_n++;
    wait_fall(got);
    a_rd = 1'b0; b_rd = 1'b0;
  endtask

  task automatic test_timeout;
    bit got;
    int hi = 1;
    do_reset;
    silent = 1'b1; a_addr = 24'h000040; a_rd = 1'b1;
    wait_rd(got);
    do begin step; if (mem_rd) hi++; end while (mem_rd && hi < 20);
    total_n++;
    if (hi !== 8 || timeout !== 1'b1) $display("FAIL tout_len: mem_rd high %0d cycles timeout=%b, required 8/1", hi, timeout);
    else pass_n++;
    step;
    total_n++;
    if (mem_rd !== 1'b1 || timeout !== 1'b0 || mem_addr !== 24'h000040)
      $display("FAIL tout_regrant: mem_rd=%b timeout=%b mem_addr=%h required 1/0/000040", mem_rd, timeout, mem_addr);
    else pass_n++;
    b_addr = 24'h000080; b_rd = 1'b1;
    wait_fall(got);
    total_n++;
    if (!got || timeout !== 1'b1) $display("FAIL tout_second: fell=%0b timeout=%b required 1/1", got, timeout);
    else pass_n++;
    step;
    total_n++;
    if (mem_rd !== 1'b1 || mem_addr !== 24'h000080) $display("FAIL tout_b_first: mem_rd=%b mem_addr=%h required 1/000080", mem_rd, mem_addr);
    else pass_n++;
    total_n++;
    if (a_ok !== 1'b0) $display("FAIL tout_a_ok: a_ok=%b required 0", a_ok);
    else pass_n++;
  endtask

  task automatic test_flush;
    bit got;
    int n = 0;
    do_reset;
    lat = 3; ovr = 8'h3C; a_addr = 24'h000200; a_rd = 1'b1;
    wait_rd(got);
    step; flush = 1'b1;
    step; flush = 1'b0;
    wait_fall(got);
    total_n++;
    if (a_ok !== 1'b0) $display("FAIL flush_kill: a_ok=%b required 0", a_ok);
    else pass_n++;
    step;
    total_n++;
    if (mem_rd !== 1'b1 || mem_addr !== 24'h000200) $display("FAIL flush_refetch: mem_rd=%b mem_addr=%h required 1/000200", mem_rd, mem_addr);
    else pass_n++;
    while (!a_ok && n < 20) begin step; n++; end
    total_n++;
    if (a_ok !== 1'b1 || a_dout !== 8'h3C) $display("FAIL flush_fill: a_ok=%b a_dout=%h required 1/3c", a_ok, a_dout);
    else pass_n++;
    flush = 1'b1;
    step; flush = 1'b0;
    total_n++;
    if (a_ok !== 1'b0) $display("FAIL flush_after: a_ok=%b required 0", a_ok);
    else pass_n++;
    a_rd = 1'b0;
  endtask

  task automatic test_stale;
    bit got;
    int glitch = 0, n = 0;
    do_reset;
    lat = 3; a_addr = 24'h000020; a_rd = 1'b1;
    wait_rd(got);
    if (mem_addr !== 24'h000020) glitch++;
    step; a_addr = 24'h000021;
    while (mem_rd && n < 20) begin
      step; n++;
      if (mem_rd && mem_addr !== 24'h000020) glitch++;
    end
    total_n++;
    if (glitch !== 0 || a_ok !== 1'b0) $display("FAIL stale_busy: glitches=%0d a_ok=%b required 0/0", glitch, a_ok);
    else pass_n++;
    step;
    total_n++;
    if (mem_rd !== 1'b1 || mem_addr !== 24'h000021) $display("FAIL stale_refetch: mem_rd=%b mem_addr=%h required 1/000021", mem_rd, mem_addr);
    else pass_n++;
    n = 0;
    while (!a_ok && n < 20) begin step; n++; end
    total_n++;
    if (a_ok !== 1'b1 || a_dout !== mem_fn(24'h000021)) $display("FAIL stale_data: a_ok=%b a_dout=%h required 1/%h", a_ok, a_dout, mem_fn(24'h000021));
    else pass_n++;
    a_rd = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit got;
    do_reset;
    silent = 1'b1; a_addr = 24'h000300; a_rd = 1'b1;
    wait_rd(got);
    step;
    rst_n = 1'b0;
    #1;
    total_n++;
    if ({mem_rd, a_ok, b_ok, timeout} !== 4'b0) $display("FAIL rst_mid: mem_rd/a_ok/b_ok/timeout=%b required 0000", {mem_rd, a_ok, b_ok, timeout});
    else pass_n++;
    b_addr = 24'h000400; b_rd = 1'b1; silent = 1'b0; lat = 2;
    step;
    rst_n = 1'b1;
    step;
    total_n++;
    if (mem_rd !== 1'b1 || mem_addr !== 24'h000300) $display("FAIL rst_tie: mem_rd=%b mem_addr=%h required 1/000300", mem_rd, mem_addr);
    else pass_n++;
    wait_fall(got);
    a_rd = 1'b0; b_rd = 1'b0;
  endtask

  task automatic test_random;
    int hits = 0, touts = 0, bad = 0, n = 0;
    do_reset;
    for (int i = 0; i < 400; i++) begin
      step;
      if (timeout) touts++;
      if (a_ok) begin
        hits++; total_n++;
        if (a_dout !== mem_fn(a_addr)) $display("FAIL rand_a: addr=%h a_dout=%h required %h", a_addr, a_dout, mem_fn(a_addr));
        else pass_n++;
      end
      if (b_ok) begin
        hits++; total_n++;
        if (b_dout !== mem_fn(b_addr)) $display("FAIL rand_b: addr=%h b_dout=%h required %h", b_addr, b_dout, mem_fn(b_addr));
        else pass_n++;
      end
      if ($urandom_range(0, 3) == 0) a_rd = !a_rd;
      if ($urandom_range(0, 3) == 0) b_rd = !b_rd;
      if ($urandom_range(0, 4) == 0) a_addr = 24'h001000 + 24'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) b_addr = 24'h002000 + 24'($urandom_range(0, 3));
      flush = ($urandom_range(0, 15) == 0);
      if (!mem_rd) lat = $urandom_range(1, 4);
    end
    flush = 1'b0; a_rd = 1'b1; b_rd = 1'b1;
    while (!(a_ok && b_ok) && n < 60) begin step; n++; if (timeout) touts++; end
    total_n++;
    if (!(a_ok && b_ok)) $display("FAIL rand_live: a_ok=%b b_ok=%b required 1/1", a_ok, b_ok);
    else pass_n++;
    total_n++;
    if (touts !== 0 || hits < 10) $display("FAIL rand_stats: timeouts=%0d hits=%0d required 0/>=10", touts, hits);
    else pass_n++;
    if (bad != 0) $display("FAIL rand_bad: %0d", bad);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_round_robin;
    test_timeout;
    test_flush;
    test_stale;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
